// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed hex display: glyph table,
// blank pattern and decimal-point bit position.
package disp_pkg;

  localparam logic [7:0] SSEG_OFF = 8'hFF;
  localparam int DP_BIT = 7;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit held off here.
  // Entry 15 is leftmost, entry 0 rightmost.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Nibble plus decimal point to active-low 7-segment pattern.
// Ports: nib (4b value), dp (1 = point on), sseg (8b, bit7 = dp).
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] sseg
);

  always_comb begin
    sseg = GLYPH[nib];
    sseg[DP_BIT] = ~dp;
  end

endmodule

// File: rtl/disp_hex_mux_n.sv
// Time-multiplexed N-digit hex display driver with PWM dimming.
// Ports: clk, reset (sync, high), hex/dp_in/blank per digit,
// bright duty code; an (active-low anodes), sseg (active-low),
// frame_tick (pulse at digit 0 start).
// Macro DISP_LZ_BLANK_EN enables leading-zero blanking.
module disp_hex_mux_n
  import disp_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int PRESC_BITS = 16,
  parameter int DIM_BITS   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   hex,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic [DIM_BITS-1:0]     bright,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int IW = $clog2(N_DIGITS);

  logic [PRESC_BITS-1:0] presc;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [3:0]            s_nib;
  logic                  s_dp;
  logic                  s_blk;
  logic                  s_lz;
  // Low until the first snapshot: keeps the post-reset slot dark.
  logic                  live;
  logic                  slot_end;
  logic                  lit;
  logic                  show;
  logic [7:0]            glyph;
  logic [N_DIGITS-1:0]   lz_vec;
  logic [N_DIGITS-1:0]   an_lit;

  assign slot_end = &presc;

  assign idx_nxt = (idx == IW'(N_DIGITS - 1))
                 ? '0 : idx + 1'b1;

`ifdef DISP_LZ_BLANK_EN
  // Zero run from the top digit down; digit 0 always shown.
  always_comb begin
    logic run;
    run    = 1'b1;
    lz_vec = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      run = run & (hex[4*k +: 4] == 4'h0) & ~dp_in[k];
      lz_vec[k] = run;
    end
  end
`else
  assign lz_vec = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= IW'(N_DIGITS - 1);
      s_nib <= '0;
      s_dp  <= 1'b0;
      s_blk <= 1'b0;
      s_lz  <= 1'b0;
      live  <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      if (slot_end) begin
        idx   <= idx_nxt;
        s_nib <= hex[4*idx_nxt +: 4];
        s_dp  <= dp_in[idx_nxt];
        s_blk <= blank[idx_nxt];
        s_lz  <= lz_vec[idx_nxt];
        live  <= 1'b1;
      end
    end
  end

  hex_to_sseg u_dec (
    .nib  (s_nib),
    .dp   (s_dp),
    .sseg (glyph)
  );

  // All-ones code bypasses the compare so it means fully on.
  assign lit = (&bright)
    || (presc[PRESC_BITS-1 -: DIM_BITS] < bright);

  assign show = live & lit & ~s_blk & ~s_lz;

  always_comb begin
    an_lit      = '1;
    an_lit[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      sseg       <= SSEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= show ? an_lit : '1;
      sseg       <= show ? glyph : SSEG_OFF;
      frame_tick <= live && (idx == '0)
                    && (presc == '0);
    end
  end

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Directed bench for disp_hex_mux_n: 4-digit and 5-digit
// instances with a 16-clock slot.
module tb_disp_hex_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [15:0] hex = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  logic        reset5 = 1'b1;
  logic [19:0] hex5 = 20'h43210;
  logic [4:0]  dp5 = '0;
  logic [4:0]  blank5 = '0;
  logic [1:0]  bright5 = 2'd3;
  logic [4:0]  an5;
  logic [7:0]  sseg5;
  logic        ft5;

  disp_hex_mux_n #(
    .N_DIGITS(4), .PRESC_BITS(4), .DIM_BITS(2)
  ) u_dut (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in),
    .blank(blank), .bright(bright), .an(an), .sseg(sseg),
    .frame_tick(frame_tick)
  );

  disp_hex_mux_n #(
    .N_DIGITS(5), .PRESC_BITS(4), .DIM_BITS(2)
  ) u_dut5 (
    .clk(clk), .reset(reset5), .hex(hex5), .dp_in(dp5),
    .blank(blank5), .bright(bright5), .an(an5),
    .sseg(sseg5), .frame_tick(ft5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0]      hex;
    logic [3:0]       dp;
    logic [3:0]       blank;
    logic [1:0]       bright;
    int               duty;
    logic [3:0]       dark;
    logic [3:0][7:0]  seg;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] h,
                              input logic [3:0] dp,
                              input logic [3:0] bl,
                              input logic [1:0] br,
                              input int duty,
                              input logic [3:0] dark,
                              input logic [31:0] segs);
    vec_t v;
    v.hex = h; v.dp = dp; v.blank = bl; v.bright = br;
    v.duty = duty; v.dark = dark; v.seg = segs;
    return v;
  endfunction

  task automatic reset4();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Edges 1..16 after reset release must stay dark.
  task automatic dark16(input string name);
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
      chk(name, {an, sseg, frame_tick},
          {4'hF, 8'hFF, 1'b0});
    end
  endtask

  // Check first cycle of a slot, then sit out the rest.
  task automatic slot_first(input string name,
                            input logic [3:0] ea,
                            input logic [7:0] es,
                            input logic eft);
    @(posedge clk);
    @(negedge clk);
    chk(name, {an, sseg, frame_tick}, {ea, es, eft});
    repeat (15) @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ea;
    logic [7:0] es;
    logic [4:0] ea5;
    logic [4:0][7:0] seg5;
    bit lit;

    vecs.push_back(mk(16'hFA53, 4'h0, 4'h0, 2'd3, 16,
      4'h0, {8'h8E, 8'h88, 8'h92, 8'hB0}));
    vecs.push_back(mk(16'hFA53, 4'h0, 4'h0, 2'd1, 4,
      4'h0, {8'h8E, 8'h88, 8'h92, 8'hB0}));
    vecs.push_back(mk(16'hFA53, 4'h0, 4'h0, 2'd2, 8,
      4'h0, {8'h8E, 8'h88, 8'h92, 8'hB0}));
    vecs.push_back(mk(16'hFA53, 4'h0, 4'h0, 2'd0, 0,
      4'h0, {8'h8E, 8'h88, 8'h92, 8'hB0}));
    vecs.push_back(mk(16'hFA53, 4'b1001, 4'b0100, 2'd3, 16,
      4'b0100, {8'h0E, 8'hFF, 8'h92, 8'h30}));
`ifdef DISP_LZ_BLANK_EN
    vecs.push_back(mk(16'h0005, 4'h0, 4'h0, 2'd3, 16,
      4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h92}));
    vecs.push_back(mk(16'h0000, 4'h0, 4'h0, 2'd3, 16,
      4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'hC0}));
    vecs.push_back(mk(16'h0005, 4'b0010, 4'h0, 2'd3, 16,
      4'b1100, {8'hFF, 8'hFF, 8'h40, 8'h92}));
`else
    vecs.push_back(mk(16'h0005, 4'h0, 4'h0, 2'd3, 16,
      4'h0, {8'hC0, 8'hC0, 8'hC0, 8'h92}));
`endif

    @(negedge clk);
    chk("reset_state", {an, sseg, frame_tick},
        {4'hF, 8'hFF, 1'b0});

    foreach (vecs[v]) begin
      hex = vecs[v].hex;
      dp_in = vecs[v].dp;
      blank = vecs[v].blank;
      bright = vecs[v].bright;
      reset4();
      dark16($sformatf("v%0d_startup", v));
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 16; c++) begin
          @(posedge clk);
          @(negedge clk);
          lit = (c < vecs[v].duty) && !vecs[v].dark[s];
          ea = 4'hF;
          if (lit) ea[s] = 1'b0;
          es = lit ? vecs[v].seg[s] : 8'hFF;
          chk($sformatf("v%0d_d%0d_c%0d", v, s, c),
              {an, sseg, frame_tick},
              {ea, es, 1'(s == 0 && c == 0)});
        end
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_frame_wrap", v), frame_tick, 1'b1);
    end

    // Mid-slot input change is held off until the next snapshot.
    hex = 16'h9410; dp_in = '0; blank = '0; bright = 2'd3;
    reset4();
    dark16("hold_startup");
    slot_first("hold_d0", 4'b1110, 8'hC0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_d1_c%0d", c), {an, sseg},
          {4'b1101, 8'hF9});
      if (c == 5) hex = 16'hCE72;
    end
    slot_first("hold_d2", 4'b1011, 8'h86, 1'b0);
    slot_first("hold_d3", 4'b0111, 8'hC6, 1'b0);
    slot_first("hold_d0b", 4'b1110, 8'hA4, 1'b1);
    slot_first("hold_d1b", 4'b1101, 8'hF8, 1'b0);

    // Bright raised mid-slot applies on the next output.
    bright = 2'd0;
    @(posedge clk);
    @(negedge clk);
    chk("bright_off", an, 4'hF);
    bright = 2'd3;
    @(posedge clk);
    @(negedge clk);
    chk("bright_on", an, 4'b1011);
    reset = 1'b1;

    // Five digits: non-power-of-two wrap and mid-slot reset.
    seg5 = {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    @(negedge clk);
    reset5 = 1'b0;
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
      chk("n5_startup", {an5, sseg5, ft5},
          {5'h1F, 8'hFF, 1'b0});
    end
    for (int s = 0; s < 7; s++) begin
      @(posedge clk);
      @(negedge clk);
      ea5 = 5'h1F;
      ea5[s % 5] = 1'b0;
      chk($sformatf("n5_slot%0d", s), {an5, sseg5, ft5},
          {ea5, seg5[s % 5], 1'((s % 5) == 0)});
      if (s < 6) repeat (15) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    reset5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("n5_reset_dark", {an5, sseg5, ft5},
        {5'h1F, 8'hFF, 1'b0});
    @(negedge clk);
    reset5 = 1'b0;
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
      chk("n5_restart_dark", an5, 5'h1F);
    end
    @(posedge clk);
    @(negedge clk);
    chk("n5_restart_d0", {an5, sseg5, ft5},
        {5'b11110, 8'hC0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
